// File: rtl/pow_share_pkg.sv
// Shared types and helpers for the shared power-engine arbiter.
package pow_share_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_W       = 18;
  localparam int DEF_EXP     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } pow_state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pow_rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after the pointer.
module pow_rr_arbiter
  import pow_share_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req_valid,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_winner
);

  always_comb begin
    int          w_pos;
    logic        w_found;
    logic [ID_W-1:0] w_idx;
    o_grant  = '0;
    o_winner = '0;
    w_found  = 1'b0;
    w_pos    = 0;
    w_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= NUM_REQ) begin
        w_pos = w_pos - NUM_REQ;
      end
      w_idx = ID_W'(w_pos);
      if (!w_found && i_req_valid[w_idx]) begin
        w_found         = 1'b1;
        o_grant[w_idx]  = 1'b1;
        o_winner        = w_idx;
      end
    end
  end

endmodule

// File: rtl/pow_share_arbiter.sv
// Round-robin sharing of one iterative n^EXP engine among NUM_REQ requesters,
// with a single id-tagged result port that honours backpressure.
module pow_share_arbiter
  import pow_share_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int W       = DEF_W,
  parameter int EXP     = DEF_EXP,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*W-1:0] req_n,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 res_valid,
  output logic [ID_W-1:0]      res_id,
  output logic [W-1:0]         res_data,
  input  logic                 res_ready,
  output logic                 busy
);

  localparam int CNT_W = id_width(EXP + 1);

  pow_state_e       r_state;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_id;
  logic [W-1:0]     r_acc;
  logic [W-1:0]     r_n;
  logic [CNT_W-1:0] r_cnt;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_winner;
  logic               w_accept;
  logic [W-1:0]       w_ops [NUM_REQ];
  logic [W-1:0]       w_opnd;
  logic [W-1:0]       w_prod;
  logic [ID_W-1:0]    w_ptr_next;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_ops
    assign w_ops[g] = req_n[g*W +: W];
  end

  pow_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .i_req_valid (req_valid),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_winner    (w_winner)
  );

  // Grants are offered only in IDLE and never while reset is held.
  assign req_ready  = (reset_n && (r_state == IDLE)) ? w_grant : '0;
  assign w_accept   = |(req_valid & req_ready);
  assign w_opnd     = w_ops[w_winner];
  assign w_prod     = W'(r_acc * r_n);
  assign w_ptr_next = (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + ID_W'(1);

  assign busy      = (r_state != IDLE);
  assign res_valid = (r_state == DONE);
  assign res_id    = r_id;
  assign res_data  = r_acc;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_id    <= '0;
      r_acc   <= '0;
      r_n     <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_n     <= w_opnd;
            r_acc   <= w_opnd;
            r_id    <= w_winner;
            r_cnt   <= CNT_W'(EXP - 1);
            r_state <= (EXP > 1) ? MUL : DONE;
          end
        end
        MUL: begin
          r_acc <= w_prod;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          // Pointer moves past the owner only once its result is taken.
          if (res_ready) begin
            r_state <= IDLE;
            r_ptr   <= w_ptr_next;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pow_share_arbiter.sv
// Scoreboard bench for pow_share_arbiter: randomized requesters against a
// behavioural round-robin/power model, plus directed known answers.
module tb_pow_share_arbiter;

  localparam int NREQ = 4;
  localparam int WD   = 18;
  localparam int EXPV = 5;
  localparam int IDW  = 2;

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic [NREQ-1:0]      reqValid;
  logic [NREQ-1:0]      reqReady;
  logic [WD-1:0]        reqN [NREQ];
  logic [NREQ*WD-1:0]   reqNFlat;
  logic                 resValid, resReady, busy;
  logic [IDW-1:0]       resId;
  logic [WD-1:0]        resData;

  logic [NREQ-1:0]      reqValid1, reqReady1;
  logic [NREQ*WD-1:0]   reqNFlat1;
  logic                 resValid1, resReady1, busy1;
  logic [IDW-1:0]       resId1;
  logic [WD-1:0]        resData1;

  typedef struct {
    int          id;
    logic [WD-1:0] data;
    longint      acceptCycle;
  } job_t;

  int              checks = 0;
  int              errors = 0;
  longint          cycleCnt = 0;
  job_t            sbq[$];
  bit              frontSeen = 1'b0;
  bit              jobOpen = 1'b0;
  int              modelPtr = 0;
  logic [NREQ-1:0] acceptedPending = '0;
  bit              logEnable = 1'b0;
  bit              refill = 1'b0;
  int              acceptIds[$];
  longint          acceptCycles[$];
  int              nextOp = 100;

  always_comb begin
    reqNFlat = '0;
    for (int i = 0; i < NREQ; i++) reqNFlat[i*WD +: WD] = reqN[i];
  end

  pow_share_arbiter #(.NUM_REQ(NREQ), .W(WD), .EXP(EXPV), .ID_W(IDW)) u_dut (
    .clock(clock), .reset_n(reset_n), .req_valid(reqValid), .req_n(reqNFlat),
    .req_ready(reqReady), .res_valid(resValid), .res_id(resId), .res_data(resData),
    .res_ready(resReady), .busy(busy)
  );

  pow_share_arbiter #(.NUM_REQ(NREQ), .W(WD), .EXP(1), .ID_W(IDW)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .req_valid(reqValid1), .req_n(reqNFlat1),
    .req_ready(reqReady1), .res_valid(resValid1), .res_id(resId1), .res_data(resData1),
    .res_ready(resReady1), .busy(busy1)
  );

  initial forever #5 clock = ~clock;
  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cycleCnt);
    end
  endtask

  function automatic logic [WD-1:0] powRef(input logic [WD-1:0] n);
    longint unsigned acc = 1;
    for (int k = 0; k < EXPV; k++) acc = (acc * longint'(n)) % (64'd1 << WD);
    return WD'(acc);
  endfunction

  function automatic logic [NREQ-1:0] rrPick(input logic [NREQ-1:0] v, input int ptr);
    logic [NREQ-1:0] g = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx = (ptr + k) % NREQ;
      if (v[idx]) begin
        g[idx] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  function automatic int oneHotIndex(input logic [NREQ-1:0] m);
    for (int i = 0; i < NREQ; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic logic [WD-1:0] randOp();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return WD'(1);
      2: return WD'(16);
      3: return WD'(13);
      default: return WD'($urandom);
    endcase
  endfunction

  // Grant checker: predicts req_ready/busy and pushes the expected result on accept.
  always @(negedge clock) begin
    logic [NREQ-1:0] expReady;
    logic [NREQ-1:0] accepted;
    int id;
    if (!reset_n) begin
      checkOutput("req_ready_in_reset", reqReady, 0);
      sbq.delete();
      frontSeen = 1'b0;
      jobOpen = 1'b0;
      modelPtr = 0;
      acceptedPending = '0;
    end else begin
      expReady = jobOpen ? '0 : rrPick(reqValid, modelPtr);
      checkOutput("req_ready", reqReady, expReady);
      checkOutput("busy", busy, jobOpen);
      accepted = reqValid & reqReady;
      if (accepted != '0) begin
        id = oneHotIndex(accepted);
        sbq.push_back('{id, powRef(reqN[id]), cycleCnt});
        jobOpen = 1'b1;
        acceptedPending = accepted;
        if (logEnable) begin
          acceptIds.push_back(id);
          acceptCycles.push_back(cycleCnt);
        end
      end
    end
  end

  // Result monitor: compares every presented result against the queue front.
  always @(negedge clock) begin
    #1;
    if (reset_n) begin
      if (sbq.size() > 0 && !frontSeen && cycleCnt == sbq[0].acceptCycle + EXPV) begin
        checkOutput("res_valid_on_time", resValid, 1);
        frontSeen = 1'b1;
      end
      if (resValid) begin
        if (sbq.size() == 0) begin
          checkOutput("res_valid_spurious", resValid, 0);
        end else begin
          checkOutput("res_id", resId, sbq[0].id);
          checkOutput("res_data", resData, sbq[0].data);
          if (!frontSeen) begin
            checkOutput("latency", cycleCnt - sbq[0].acceptCycle, EXPV);
            frontSeen = 1'b1;
          end
          if (resReady) begin
            modelPtr = (sbq[0].id + 1) % NREQ;
            void'(sbq.pop_front());
            frontSeen = 1'b0;
            jobOpen = 1'b0;
          end
        end
      end
    end
  end

  task automatic applyStimulus();
    @(posedge clock);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acceptedPending[i]) begin
        if (refill) begin
          reqN[i] = WD'(nextOp);
          nextOp++;
        end else begin
          reqValid[i] = 1'b0;
        end
      end
    end
    acceptedPending = '0;
  endtask

  task automatic waitResult(input int expId, input int expData);
    bit got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clock);
      #2;
      if (resValid && resReady) begin
        checkOutput("known_id", resId, expId);
        checkOutput("known_data", resData, expData);
        got = 1'b1;
      end else begin
        applyStimulus();
      end
    end
    if (!got) checkOutput("known_timeout", resValid, 1);
  endtask

  task automatic drain();
    applyStimulus();
    reset_n = 1'b1;
    reqValid = '0;
    resReady = 1'b1;
    for (int t = 0; t < 100; t++) begin
      if (!jobOpen && sbq.size() == 0) break;
      applyStimulus();
    end
    checkOutput("drain_idle", busy, 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int kaId[5]  = '{2, 0, 1, 3, 2};
    int kaN[5]   = '{3, 16, 13, 0, 1};
    int kaExp[5] = '{243, 0, 109149, 0, 1};

    reset_n   = 1'b0;
    reqValid  = '1;
    for (int i = 0; i < NREQ; i++) reqN[i] = randOp();
    resReady  = 1'b0;
    reqValid1 = '0;
    reqNFlat1 = '0;
    resReady1 = 1'b0;

    repeat (3) applyStimulus();
    reqValid = '0;
    reset_n  = 1'b1;
    @(negedge clock);
    #2;
    checkOutput("reset_res_valid", resValid, 0);
    checkOutput("reset_res_id", resId, 0);
    checkOutput("reset_res_data", resData, 0);
    checkOutput("reset_busy", busy, 0);

    // Single-multiply build: result one cycle after accept.
    applyStimulus();
    reqValid1 = 4'b0001;
    reqNFlat1[WD-1:0] = WD'(7);
    resReady1 = 1'b1;
    @(negedge clock);
    checkOutput("exp1_ready", reqReady1, 4'b0001);
    applyStimulus();
    reqValid1 = '0;
    @(negedge clock);
    checkOutput("exp1_valid", resValid1, 1);
    checkOutput("exp1_data", resData1, 7);
    checkOutput("exp1_id", resId1, 0);
    applyStimulus();
    @(negedge clock);
    checkOutput("exp1_after_valid", resValid1, 0);
    checkOutput("exp1_after_busy", busy1, 0);

    // Known answers, one requester at a time.
    for (int k = 0; k < 5; k++) begin
      applyStimulus();
      resReady = 1'b1;
      reqValid[kaId[k]] = 1'b1;
      reqN[kaId[k]] = WD'(kaN[k]);
      waitResult(kaId[k], kaExp[k]);
      applyStimulus();
      @(negedge clock);
      #2;
      checkOutput("busy_after_handshake", busy, 0);
    end

    // All requesters continuously valid from a fresh pointer.
    applyStimulus();
    reset_n = 1'b0;
    applyStimulus();
    reset_n = 1'b1;
    logEnable = 1'b1;
    refill = 1'b1;
    resReady = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      reqValid[i] = 1'b1;
      reqN[i] = WD'(nextOp);
      nextOp++;
    end
    repeat (30) applyStimulus();
    refill = 1'b0;
    logEnable = 1'b0;
    reqValid = '0;
    checkOutput("rr_accept_count", acceptIds.size() >= 5, 1);
    if (acceptIds.size() >= 5) begin
      for (int k = 0; k < 5; k++) checkOutput("rr_order", acceptIds[k], k % NREQ);
      for (int k = 1; k < 5; k++) checkOutput("rr_period", acceptCycles[k] - acceptCycles[k-1], EXPV + 1);
    end
    drain();

    // Backpressure: result held while the consumer stalls.
    reqValid[3] = 1'b1;
    reqN[3] = WD'(7);
    reqValid[1] = 1'b1;
    reqN[1] = WD'(5);
    resReady = 1'b0;
    repeat (14) applyStimulus();
    checkOutput("bp_hold_valid", resValid, 1);
    checkOutput("bp_hold_ready", reqReady, 0);
    resReady = 1'b1;
    drain();

    // Reset in the second multiply cycle aborts the job.
    reqValid[0] = 1'b1;
    reqN[0] = WD'(5);
    applyStimulus();
    applyStimulus();
    reset_n = 1'b0;
    applyStimulus();
    reset_n = 1'b1;
    @(negedge clock);
    #2;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_res_valid", resValid, 0);
    applyStimulus();
    reqValid[1] = 1'b1;
    reqN[1] = WD'(9);
    reqValid[3] = 1'b1;
    reqN[3] = WD'(2);
    waitResult(1, 59049);
    drain();

    // Randomized traffic with stalls, drops and occasional resets.
    for (int t = 0; t < 2500; t++) begin
      applyStimulus();
      reset_n  = ($urandom_range(0, 299) != 0);
      resReady = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!reqValid[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            reqValid[i] = 1'b1;
            reqN[i] = randOp();
          end
        end else if ($urandom_range(0, 39) == 0) begin
          reqValid[i] = 1'b0;
        end
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pow_share_arbiter.md
Name: pow_share_arbiter

Overview:
Shares one sequential power engine (single W-bit multiplier, iterative n^EXP) among NUM_REQ requesters. Round-robin arbitration, valid/ready handshake per requester, one result port tagged with the requester id, with backpressure. Sits between several client blocks and the multiplier resource; only one computation is in flight at a time.

Parameters:
NUM_REQ, 4, number of requesters (>= 2)
W, 18, operand/result width
EXP, 5, exponent (>= 1); EXP-1 multiplies per job
ID_W, $clog2(NUM_REQ), width of res_id

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_n  input  NUM_REQ*W  operands, requester i at bits [i*W +: W]
req_ready  output  NUM_REQ  one-hot grant/accept, combinational
res_valid  output  1  result valid
res_id  output  ID_W  index of requester owning the result
res_data  output  W  n^EXP mod 2^W
res_ready  input  1  consumer accepts result
busy  output  1  high when state != IDLE

Behaviour:
- Reset: reset_n sampled low at a rising edge -> state IDLE, rr pointer 0, res_valid 0, res_id 0, res_data 0, counter 0. While reset_n low, req_ready = 0.
- Reset mid-operation aborts the job; no res_valid is produced for it; the requester is not re-served automatically.
- States: IDLE, MUL, DONE.
- IDLE: if any req_valid, winner = first index with req_valid at or after pointer, wrapping modulo NUM_REQ; req_ready[winner] = 1, all others 0. Accept = req_valid & req_ready in that cycle. On accept edge: r_n <= req_n[winner], acc <= req_n[winner], id <= winner, cnt <= EXP-1; next state MUL if EXP > 1, else DONE. No valid requests -> stay IDLE, req_ready all 0.
- req_ready is never asserted outside IDLE. A requester holds valid and operand until ready; dropping valid before grant is legal, and arbitration is re-evaluated every cycle.
- MUL: each cycle acc <= (acc * r_n) truncated to low W bits; cnt decrements; when cnt reaches 1 before the edge, move to DONE with final product.
- DONE: res_valid = 1, res_data = acc, res_id = id, all stable until res_valid & res_ready. On that edge: -> IDLE, pointer <= (id + 1) mod NUM_REQ.
- Latency: accept in cycle c -> res_valid first high in cycle c+EXP. With res_ready held high, next accept is possible at c+EXP+1 (throughput 1 job per EXP+1 cycles).
- Arithmetic: all products unsigned, modulo 2^W; 0^EXP = 0, 1^EXP = 1.
- Fairness: a continuously-valid requester is granted within NUM_REQ jobs.
- busy = (state != IDLE); res_valid = (state == DONE).

Decomposition:
- Shared package pow_share_pkg: state enum (IDLE, MUL, DONE), ID-width helper function, default W/EXP constants.
- Sub-module pow_rr_arbiter: combinational, takes req_valid and pointer, returns one-hot grant and encoded winner index. FSM, counter and datapath stay in the top.

Test Plan:
- Single requester 2, n=3, EXP=5, res_ready=1 -> req_ready[2] in cycle c, res_valid in c+5 with res_data=243 and res_id=2, busy low at c+6.
- Truncation: n=16 -> res_data=0; n=13 -> res_data=109149 (371293 mod 2^18); n=0 -> 0; n=1 -> 1.
- All 4 requesters valid continuously, distinct n -> grant order 0,1,2,3,0. Each res_id matches its operand, period 6 cycles.
- Backpressure: res_ready low 3 cycles in DONE -> res_valid/res_data/res_id stable, req_ready all 0; after handshake, IDLE next cycle.
- Reset asserted in second MUL cycle -> next cycle IDLE, res_valid 0, pointer 0. A new request from requester 1 then completes normally.
- EXP=1 build: n=7 accepted in cycle c -> res_valid in c+1 with res_data=7.
